// File: rtl/pe_array_rs_if.sv
// Handshake buses of the row-stationary PE array: weight load, iact stream,
// incoming partial sums and the psum result channel.
interface pe_array_rs_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int PSUM_WIDTH  = 32,
  parameter int ARRAY_WIDTH = 4,
  parameter int IACT_ROWS   = 6
);
  logic                              w_valid;
  logic                              w_ready;
  logic [DATA_WIDTH-1:0]             w_data;
  logic                              iact_valid;
  logic                              iact_ready;
  logic [IACT_ROWS*DATA_WIDTH-1:0]   iact_data;
  logic [ARRAY_WIDTH*PSUM_WIDTH-1:0] psum_in;
  logic                              psum_out_valid;
  logic                              psum_out_ready;
  logic [ARRAY_WIDTH*PSUM_WIDTH-1:0] psum_out;

  modport master (
    output w_valid, w_data, iact_valid, iact_data, psum_in, psum_out_ready,
    input  w_ready, iact_ready, psum_out_valid, psum_out
  );
  modport slave (
    input  w_valid, w_data, iact_valid, iact_data, psum_in, psum_out_ready,
    output w_ready, iact_ready, psum_out_valid, psum_out
  );
endinterface

// File: rtl/pe_array_rs.sv
// Row-stationary PE array: each PE row holds one filter row, each PE column
// produces one output row; column psums are reduced over the PE rows.
module pe_array_rs #(
  parameter int DATA_WIDTH   = 16,
  parameter int PSUM_WIDTH   = 32,
  parameter int ARRAY_WIDTH  = 4,
  parameter int ARRAY_HEIGHT = 3,
  parameter int STRIDE       = 1,
  parameter int MAX_FILTER   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          filter_size,
  input  logic [3:0]          stride,
  input  logic [7:0]          row_len,
  input  logic                accumulate,
  pe_array_rs_if.slave        bus,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);
  localparam int IACT_ROWS = (ARRAY_WIDTH - 1) * STRIDE + ARRAY_HEIGHT;
  localparam logic [3:0] MAX_S    = 4'(MAX_FILTER);
  localparam logic [3:0] LAST_ROW = 4'(ARRAY_HEIGHT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_MAC    = 3'd3;
  localparam logic [2:0] S_SUM    = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0] state_r, next_s;
  logic [3:0] s_r, st_r, ph_r, wr_r, wk_r, k_r;
  logic [7:0] len_r, n_r;
  logic       acc_en_r;
  logic       w_ready_r, iact_ready_r, out_valid_r, busy_r, done_r, cfg_err_r;
  logic [ARRAY_WIDTH*PSUM_WIDTH-1:0] psum_out_r;

  logic signed [DATA_WIDTH-1:0] w_r   [ARRAY_HEIGHT][MAX_FILTER];
  logic signed [DATA_WIDTH-1:0] win_r [ARRAY_HEIGHT][ARRAY_WIDTH][MAX_FILTER];
  logic signed [PSUM_WIDTH-1:0] acc_r [ARRAY_HEIGHT][ARRAY_WIDTH];

  logic signed [DATA_WIDTH-1:0] w_tap_s   [ARRAY_HEIGHT];
  logic signed [DATA_WIDTH-1:0] win_tap_s [ARRAY_HEIGHT][ARRAY_WIDTH];
  logic signed [PSUM_WIDTH-1:0] sum_s     [ARRAY_WIDTH];
  logic [3:0] tap_idx_s;
  logic [7:0] n_next_s;
  logic cfg_bad_s, w_fire_s, w_last_s, iact_fire_s, win_fire_s, mac_last_s;

  // Full-precision signed product, then sign-extended or wrapped to the psum width.
  function automatic logic signed [PSUM_WIDTH-1:0] mac_prod(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] p;
    p = a * b;
    return PSUM_WIDTH'(p);
  endfunction

  assign cfg_bad_s   = (filter_size == 4'd0) || (filter_size > MAX_S) ||
                       (stride == 4'd0) || (row_len < {4'd0, filter_size});
  assign w_fire_s    = bus.w_valid && w_ready_r;
  assign w_last_s    = (wr_r == LAST_ROW) && (wk_r == s_r - 4'd1);
  assign iact_fire_s = bus.iact_valid && iact_ready_r;
  assign n_next_s    = n_r + 8'd1;
  assign win_fire_s  = (n_next_s >= {4'd0, s_r}) && (ph_r == 4'd0);
  assign mac_last_s  = (k_r == s_r - 4'd1);
  assign tap_idx_s   = s_r - 4'd1 - k_r;

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE:   if (start && !cfg_bad_s) next_s = S_LOAD_W; else next_s = S_IDLE;
      S_LOAD_W: if (w_fire_s && w_last_s) next_s = S_STREAM; else next_s = S_LOAD_W;
      S_STREAM: begin
        if (iact_fire_s && win_fire_s)             next_s = S_MAC;
        else if (iact_fire_s && n_next_s == len_r) next_s = S_DONE;
        else                                       next_s = S_STREAM;
      end
      S_MAC:    if (mac_last_s) next_s = S_SUM; else next_s = S_MAC;
      S_SUM:    next_s = S_OUT;
      S_OUT: begin
        if (bus.psum_out_ready) next_s = (n_r == len_r) ? S_DONE : S_STREAM;
        else                    next_s = S_OUT;
      end
      S_DONE:   next_s = S_IDLE;
      default:  next_s = S_IDLE;
    endcase
  end

  // Per-PE operand selection for the current MAC tap and the column reduction.
  always_comb begin
    for (int r = 0; r < ARRAY_HEIGHT; r++) begin
      w_tap_s[r] = '0;
      for (int k = 0; k < MAX_FILTER; k++)
        w_tap_s[r] = (4'(k) == k_r) ? w_r[r][k] : w_tap_s[r];
      for (int c = 0; c < ARRAY_WIDTH; c++) begin
        win_tap_s[r][c] = '0;
        for (int t = 0; t < MAX_FILTER; t++)
          win_tap_s[r][c] = (4'(t) == tap_idx_s) ? win_r[r][c][t] : win_tap_s[r][c];
      end
    end
    for (int c = 0; c < ARRAY_WIDTH; c++) begin
      sum_s[c] = acc_en_r ? signed'(bus.psum_in[c*PSUM_WIDTH +: PSUM_WIDTH]) : '0;
      for (int r = 0; r < ARRAY_HEIGHT; r++)
        sum_s[c] = sum_s[c] + acc_r[r][c];
    end
  end

  // Control state, job configuration, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      s_r <= 4'd0; st_r <= 4'd0; len_r <= 8'd0; acc_en_r <= 1'b0;
      n_r <= 8'd0; ph_r <= 4'd0; wr_r <= 4'd0; wk_r <= 4'd0; k_r <= 4'd0;
      w_ready_r <= 1'b0; iact_ready_r <= 1'b0; out_valid_r <= 1'b0;
      busy_r <= 1'b0; done_r <= 1'b0; cfg_err_r <= 1'b0;
    end else begin
      state_r      <= next_s;
      w_ready_r    <= (next_s == S_LOAD_W);
      iact_ready_r <= (next_s == S_STREAM);
      out_valid_r  <= (next_s == S_OUT);
      busy_r       <= (next_s != S_IDLE);
      done_r       <= (next_s == S_DONE);
      cfg_err_r    <= (state_r == S_IDLE) && start && cfg_bad_s;
      if (state_r == S_IDLE && start && !cfg_bad_s) begin
        s_r <= filter_size; st_r <= stride; len_r <= row_len; acc_en_r <= accumulate;
        n_r <= 8'd0; ph_r <= 4'd0; wr_r <= 4'd0; wk_r <= 4'd0;
      end
      if (w_fire_s) begin
        if (wk_r == s_r - 4'd1) begin
          wk_r <= 4'd0;
          wr_r <= wr_r + 4'd1;
        end else begin
          wk_r <= wk_r + 4'd1;
        end
      end
      // Stride phase counts elements since the last window instead of dividing.
      if (iact_fire_s) begin
        n_r <= n_next_s;
        if (n_next_s >= {4'd0, s_r})
          ph_r <= (ph_r == st_r - 4'd1) ? 4'd0 : ph_r + 4'd1;
      end
      k_r <= (state_r == S_MAC) ? k_r + 4'd1 : 4'd0;
    end
  end

  // Weights, iact windows, accumulators and the output psum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ARRAY_HEIGHT; r++) begin
        for (int k = 0; k < MAX_FILTER; k++) w_r[r][k] <= '0;
        for (int c = 0; c < ARRAY_WIDTH; c++) begin
          acc_r[r][c] <= '0;
          for (int t = 0; t < MAX_FILTER; t++) win_r[r][c][t] <= '0;
        end
      end
      psum_out_r <= '0;
    end else begin
      for (int r = 0; r < ARRAY_HEIGHT; r++) begin
        for (int k = 0; k < MAX_FILTER; k++)
          if (w_fire_s && wr_r == 4'(r) && wk_r == 4'(k)) w_r[r][k] <= bus.w_data;
        for (int c = 0; c < ARRAY_WIDTH; c++) begin
          if (iact_fire_s) begin
            win_r[r][c][0] <= bus.iact_data[(c*STRIDE + r)*DATA_WIDTH +: DATA_WIDTH];
            for (int t = 1; t < MAX_FILTER; t++) win_r[r][c][t] <= win_r[r][c][t-1];
          end
          if (iact_fire_s && win_fire_s)
            acc_r[r][c] <= '0;
          else if (state_r == S_MAC)
            acc_r[r][c] <= acc_r[r][c] + mac_prod(w_tap_s[r], win_tap_s[r][c]);
        end
      end
      if (state_r == S_SUM)
        for (int c = 0; c < ARRAY_WIDTH; c++)
          psum_out_r[c*PSUM_WIDTH +: PSUM_WIDTH] <= sum_s[c];
    end
  end

  assign bus.w_ready        = w_ready_r;
  assign bus.iact_ready     = iact_ready_r;
  assign bus.psum_out_valid = out_valid_r;
  assign bus.psum_out       = psum_out_r;
  assign busy               = busy_r;
  assign done               = done_r;
  assign cfg_err            = cfg_err_r;
endmodule

// File: tb/tb_pe_array_rs.sv
// Bench for pe_array_rs: a 32-bit and a 16-bit psum instance share one stimulus
// stream; a reference convolution feeds a scoreboard queue checked on every output.
module tb_pe_array_rs;
  localparam int DW = 16, AW = 4, AH = 3, ST = 1, MF = 8;
  localparam int IR = (AW - 1) * ST + AH;

  logic clk = 1'b0;
  logic rst, start, accumulate;
  logic [3:0] filter_size, stride_cfg;
  logic [7:0] row_len;
  logic busy, done, cfg_err, busy16, done16, cfg_err16;

  always #5 clk = ~clk;

  pe_array_rs_if #(.DATA_WIDTH(DW), .PSUM_WIDTH(32), .ARRAY_WIDTH(AW), .IACT_ROWS(IR)) bus ();
  pe_array_rs_if #(.DATA_WIDTH(DW), .PSUM_WIDTH(16), .ARRAY_WIDTH(AW), .IACT_ROWS(IR)) bus16 ();

  assign bus16.w_valid        = bus.w_valid;
  assign bus16.w_data         = bus.w_data;
  assign bus16.iact_valid     = bus.iact_valid;
  assign bus16.iact_data      = bus.iact_data;
  assign bus16.psum_out_ready = bus.psum_out_ready;
  for (genvar c = 0; c < AW; c++) begin : g_pin
    assign bus16.psum_in[c*16 +: 16] = bus.psum_in[c*32 +: 16];
  end

  pe_array_rs #(.DATA_WIDTH(DW), .PSUM_WIDTH(32), .ARRAY_WIDTH(AW), .ARRAY_HEIGHT(AH),
                .STRIDE(ST), .MAX_FILTER(MF)) dut (
    .clk(clk), .rst(rst), .start(start), .filter_size(filter_size), .stride(stride_cfg),
    .row_len(row_len), .accumulate(accumulate), .bus(bus.slave),
    .busy(busy), .done(done), .cfg_err(cfg_err));

  pe_array_rs #(.DATA_WIDTH(DW), .PSUM_WIDTH(16), .ARRAY_WIDTH(AW), .ARRAY_HEIGHT(AH),
                .STRIDE(ST), .MAX_FILTER(MF)) dut16 (
    .clk(clk), .rst(rst), .start(start), .filter_size(filter_size), .stride(stride_cfg),
    .row_len(row_len), .accumulate(accumulate), .bus(bus16.slave),
    .busy(busy16), .done(done16), .cfg_err(cfg_err16));

  typedef struct { logic [127:0] p32; logic [63:0] p16; } exp_t;
  typedef struct {
    int s; int st; int l; bit acc; int mode; int outs; int lat;
    bit has_k; logic [31:0] k0; logic [31:0] k1; logic [15:0] k16;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_vec = 0, n_fail = 0, job_outs = 0;
  logic [31:0] first0, first1;
  logic [15:0] first16;
  logic signed [DW-1:0] ws [AH][MF];
  logic signed [DW-1:0] xs [IR][256];
  int cur_s, cur_l;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every psum handshake pops one reference record.
  always @(negedge clk) begin
    if (bus.psum_out_valid === 1'b1 && bus.psum_out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 128'd1, 128'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("psum_out32", bus.psum_out, mon_e.p32);
        check("psum_out16", {64'd0, bus16.psum_out}, {64'd0, mon_e.p16});
        check("valid16", {127'd0, bus16.psum_out_valid}, 128'd1);
        if (job_outs == 0) begin
          first0  = bus.psum_out[31:0];
          first1  = bus.psum_out[63:32];
          first16 = bus16.psum_out[15:0];
        end
        job_outs++;
      end
    end
  end

  task automatic setup_job(input int s, input int st, input int l, input bit acc, input int mode);
    longint v;
    exp_t e;
    cur_s = s; cur_l = l;
    for (int r = 0; r < AH; r++)
      for (int k = 0; k < MF; k++)
        ws[r][k] = (mode == 0) ? 16'sd1 : (mode == 1) ? 16'sh7FFF : DW'($urandom);
    for (int k = 0; k < IR; k++)
      for (int m = 0; m < l; m++)
        xs[k][m] = (mode == 0) ? DW'(k + m) : (mode == 1) ? 16'sh8000 : DW'($urandom);
    for (int j = 0; j * st + s <= l; j++) begin
      for (int c = 0; c < AW; c++) begin
        v = acc ? longint'(100 * c) : 64'sd0;
        for (int r = 0; r < AH; r++)
          for (int k = 0; k < s; k++)
            v += longint'(ws[r][k]) * longint'(xs[c*ST + r][j*st + k]);
        e.p32[c*32 +: 32] = v[31:0];
        e.p16[c*16 +: 16] = v[15:0];
      end
      exp_q.push_back(e);
    end
    filter_size = 4'(s); stride_cfg = 4'(st); row_len = 8'(l); accumulate = acc;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("busy_after_start", {127'd0, busy}, 128'd1);
    check("w_ready_after_start", {127'd0, bus.w_ready}, 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input bit iact);
    int cyc = 0;
    forever begin
      @(negedge clk);
      if ((iact ? bus.iact_ready : bus.w_ready) === 1'b1) break;
      cyc++;
      if (cyc > 200) begin
        check(iact ? "iact_ready_timeout" : "w_ready_timeout", 128'd0, 128'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_weights();
    for (int r = 0; r < AH; r++)
      for (int k = 0; k < cur_s; k++) begin
        bus.w_valid = 1'b1;
        bus.w_data  = ws[r][k];
        wait_ready(1'b0);
      end
    bus.w_valid = 1'b0;
  endtask

  task automatic send_iacts(input int from, input int to);
    for (int m = from; m < to; m++) begin
      bus.iact_valid = 1'b1;
      for (int k = 0; k < IR; k++) bus.iact_data[k*DW +: DW] = xs[k][m];
      wait_ready(1'b1);
    end
    bus.iact_valid = 1'b0;
  endtask

  task automatic wait_done(input int lat);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1; else cyc++;
    end
    check("done_seen", {127'd0, seen}, 128'd1);
    if (lat >= 0) check("done_latency", 128'(cyc), 128'(lat));
    check("done16", {127'd0, done16}, 128'd1);
    @(negedge clk);
    check("done_one_cycle", {127'd0, done}, 128'd0);
    check("busy_back_idle", {127'd0, busy}, 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    int bad[4][3];
    logic [127:0] held;
    int cyc;
    vt[0] = '{s:3, st:1, l:6,  acc:0, mode:0, outs:4, lat:5,  has_k:1, k0:32'd18, k1:32'd27, k16:16'd18};
    vt[1] = '{s:2, st:2, l:7,  acc:0, mode:0, outs:3, lat:0,  has_k:1, k0:32'd9,  k1:32'd15, k16:16'd9};
    vt[2] = '{s:3, st:1, l:6,  acc:1, mode:0, outs:4, lat:5,  has_k:1, k0:32'd18, k1:32'd127, k16:16'd18};
    vt[3] = '{s:3, st:2, l:8,  acc:0, mode:2, outs:3, lat:-1, has_k:0, k0:32'd0,  k1:32'd0,  k16:16'd0};
    vt[4] = '{s:8, st:3, l:10, acc:1, mode:2, outs:1, lat:-1, has_k:0, k0:32'd0,  k1:32'd0,  k16:16'd0};
    vt[5] = '{s:1, st:1, l:1,  acc:0, mode:0, outs:1, lat:3,  has_k:1, k0:32'd3,  k1:32'd6,  k16:16'd3};
    vt[6] = '{s:5, st:4, l:12, acc:0, mode:0, outs:2, lat:-1, has_k:1, k0:32'd45, k1:32'd60, k16:16'd45};
    vt[7] = '{s:1, st:1, l:3,  acc:0, mode:1, outs:3, lat:3,  has_k:1, k0:32'h40018000,
              k1:32'h40018000, k16:16'h8000};
    bad = '{'{9, 1, 10}, '{3, 0, 6}, '{4, 1, 3}, '{0, 1, 6}};

    rst = 1'b1; start = 1'b0; accumulate = 1'b0;
    filter_size = 4'd0; stride_cfg = 4'd0; row_len = 8'd0;
    bus.w_valid = 1'b0; bus.w_data = '0; bus.iact_valid = 1'b0; bus.iact_data = '0;
    bus.psum_out_ready = 1'b1;
    for (int c = 0; c < AW; c++) bus.psum_in[c*32 +: 32] = 32'(100 * c);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_psum_out", bus.psum_out, 128'd0);
    check("rst_valid", {127'd0, bus.psum_out_valid}, 128'd0);
    check("rst_ready", {126'd0, bus.w_ready, bus.iact_ready}, 128'd0);
    check("rst_done_err", {126'd0, done, cfg_err}, 128'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      job_outs = 0;
      setup_job(vt[i].s, vt[i].st, vt[i].l, vt[i].acc, vt[i].mode);
      do_start();
      send_weights();
      send_iacts(0, vt[i].l);
      wait_done(vt[i].lat);
      check("job_output_count", 128'(job_outs), 128'(vt[i].outs));
      check("queue_drained", 128'(exp_q.size()), 128'd0);
      if (vt[i].has_k) begin
        check("first_col0", {96'd0, first0}, {96'd0, vt[i].k0});
        check("first_col1", {96'd0, first1}, {96'd0, vt[i].k1});
        check("first16_col0", {112'd0, first16}, {112'd0, vt[i].k16});
      end
    end

    // Output back-pressure: valid and data hold, no iact accepted, no extra output.
    job_outs = 0;
    setup_job(3, 1, 6, 1'b0, 0);
    bus.psum_out_ready = 1'b0;
    do_start();
    send_weights();
    send_iacts(0, 3);
    cyc = 0;
    while (bus.psum_out_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    check("stall_valid_seen", {127'd0, bus.psum_out_valid}, 128'd1);
    held = bus.psum_out;
    check("stall_first", held[63:0], {32'd27, 32'd18});
    bus.iact_valid = 1'b1;
    for (int k = 0; k < IR; k++) bus.iact_data[k*DW +: DW] = xs[k][3];
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("stall_valid_hold", {127'd0, bus.psum_out_valid}, 128'd1);
      check("stall_data_hold", bus.psum_out, held);
      check("stall_iact_ready", {127'd0, bus.iact_ready}, 128'd0);
    end
    check("stall_no_output", 128'(job_outs), 128'd0);
    @(posedge clk); #1 bus.psum_out_ready = 1'b1;
    send_iacts(3, 6);
    wait_done(-1);
    check("stall_output_count", 128'(job_outs), 128'd4);

    // Rejected configurations.
    for (int b = 0; b < 4; b++) begin
      filter_size = 4'(bad[b][0]); stride_cfg = 4'(bad[b][1]); row_len = 8'(bad[b][2]);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("cfg_err_pulse", {127'd0, cfg_err}, 128'd1);
      check("cfg_err_busy", {126'd0, busy, bus.w_ready}, 128'd0);
      @(negedge clk);
      check("cfg_err_clear", {125'd0, cfg_err, busy, bus.w_ready}, 128'd0);
      @(posedge clk); #1;
    end

    // Reset in the second MAC cycle with start asserted alongside, then a clean rerun.
    job_outs = 0;
    setup_job(3, 1, 6, 1'b0, 0);
    do_start();
    send_weights();
    send_iacts(0, 3);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midmac_rst_busy", {126'd0, busy, busy16}, 128'd0);
    check("midmac_rst_psum", bus.psum_out, 128'd0);
    check("midmac_rst_flags", {123'd0, bus.psum_out_valid, bus.iact_ready, bus.w_ready, done, cfg_err}, 128'd0);
    @(posedge clk); #1;
    job_outs = 0;
    setup_job(3, 1, 6, 1'b0, 0);
    do_start();
    send_weights();
    send_iacts(0, 6);
    wait_done(5);
    check("rerun_output_count", 128'(job_outs), 128'd4);
    check("rerun_col0", {96'd0, first0}, 128'd18);
    check("rerun_col1", {96'd0, first1}, 128'd27);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
